// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the SDRAM frame reader: FSM states, pixel-entry
// pieces and the controller read latency.
package frame_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int READ_LATENCY = 1;
   localparam int COLOR_WIDTH  = 8;
   localparam int NUM_COLORS   = 4;
   localparam int FLAG_WIDTH   = 2;

   typedef struct packed {
      logic [COLOR_WIDTH-1:0] red;
      logic [COLOR_WIDTH-1:0] green;
      logic [COLOR_WIDTH-1:0] blue;
      logic [COLOR_WIDTH-1:0] gray;
   } colour_t;

   typedef struct packed {
      logic sof;
      logic eof;
   } flags_t;

   // Buffer entry: colours, x, y, then flags.
   function automatic int entry_width(input int dim_width);
      return NUM_COLORS * COLOR_WIDTH + 2 * dim_width + FLAG_WIDTH;
   endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock FIFO with synchronous reset, occupancy count and simultaneous
// push/pop. DEPTH must be a power of two so the pointers wrap naturally.
module pixel_sync_fifo
   import frame_reader_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push_s;
   logic             do_pop_s;
   logic             full_s;

   assign empty_o   = (count_q == '0);
   assign full_s    = (count_q == CNT_MAX);
   assign do_pop_s  = pop_i && !empty_o;
   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   assign do_push_s = push_i && (!full_s || do_pop_s);
   assign data_o    = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sdram_frame_reader.sv
// Reads one frame from the SDRAM controller read port, one pixel per request,
// and re-emits it as a valid/ready raster stream with coordinates and frame markers.
module sdram_frame_reader
   import frame_reader_pkg::*;
#(
   parameter int BUFFER_DEPTH = 4,
   parameter int DIM_WIDTH    = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DIM_WIDTH-1:0] width,
   input  logic [DIM_WIDTH-1:0] height,
   input  logic                 iStart,
   output logic                 oRead,
   input  logic [7:0]           iRed,
   input  logic [7:0]           iGreen,
   input  logic [7:0]           iBlue,
   input  logic [7:0]           iGray,
   output logic                 oValid,
   input  logic                 iReady,
   output logic [7:0]           oRed,
   output logic [7:0]           oGreen,
   output logic [7:0]           oBlue,
   output logic [7:0]           oGray,
   output logic [DIM_WIDTH-1:0] oX,
   output logic [DIM_WIDTH-1:0] oY,
   output logic                 oStartOfFrame,
   output logic                 oEndOfFrame,
   output logic                 oBusy,
   output logic                 oDone
);

   localparam int CNT_W   = $clog2(BUFFER_DEPTH) + 1;
   localparam int CW      = CNT_W + 1;
   localparam int ENTRY_W = entry_width(DIM_WIDTH);
   localparam logic [CNT_W:0]       DEPTH_C = CW'(BUFFER_DEPTH);
   localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

   typedef struct packed {
      logic [DIM_WIDTH-1:0] x;
      logic [DIM_WIDTH-1:0] y;
      flags_t               flags;
   } meta_t;

   typedef struct packed {
      colour_t colour;
      meta_t   meta;
   } entry_t;

   state_e               state_q, state_d;
   logic [DIM_WIDTH-1:0] w_q, w_d;
   logic [DIM_WIDTH-1:0] h_q, h_d;
   logic [DIM_WIDTH-1:0] rx_q, rx_d;
   logic [DIM_WIDTH-1:0] ry_q, ry_d;
   logic [READ_LATENCY-1:0] inflight_q;
   meta_t                meta_q [READ_LATENCY];

   logic                 read_s;
   logic                 done_s;
   logic                 last_x_s;
   logic                 last_y_s;
   logic                 inflight_s;
   logic                 pop_s;
   logic                 empty_s;
   logic [CNT_W-1:0]     occupancy_s;
   logic [CNT_W:0]       credit_s;
   logic                 credit_ok_s;
   meta_t                req_meta_s;
   entry_t               push_entry_s;
   entry_t               head_s;
   logic [ENTRY_W-1:0]   head_bits_s;

   assign last_x_s   = (rx_q == w_q - DIM_ONE);
   assign last_y_s   = (ry_q == h_q - DIM_ONE);
   assign inflight_s = |inflight_q;
   assign pop_s      = !empty_s && iReady;

   // Occupancy plus the outstanding read, minus what leaves this cycle, must leave a free slot.
   assign credit_s    = {1'b0, occupancy_s} + CW'(inflight_s) - CW'(pop_s);
   assign credit_ok_s = (credit_s < DEPTH_C);

   assign req_meta_s.x         = rx_q;
   assign req_meta_s.y         = ry_q;
   assign req_meta_s.flags.sof = (rx_q == '0) && (ry_q == '0);
   assign req_meta_s.flags.eof = last_x_s && last_y_s;

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      h_d     = h_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      read_s  = 1'b0;
      done_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iStart && (width != '0) && (height != '0)) begin
               state_d = ST_RUN;
               w_d     = width;
               h_d     = height;
               rx_d    = '0;
               ry_d    = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            read_s = credit_ok_s;
            if (read_s && last_x_s) begin
               rx_d = '0;
               if (last_y_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  ry_d = ry_q + DIM_ONE;
               end
            end else if (read_s) begin
               rx_d = rx_q + DIM_ONE;
            end else begin
               rx_d = rx_q;
            end
         end
         ST_DRAIN: begin
            if (pop_s && head_s.meta.flags.eof) begin
               done_s  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         w_q     <= '0;
         h_q     <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         h_q     <= h_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
      end
   end

   // Request tags travel alongside the read so they meet the returned data.
   always_ff @(posedge clock) begin
      if (reset) begin
         inflight_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            meta_q[i] <= '0;
         end
      end else begin
         inflight_q[0] <= read_s;
         meta_q[0]     <= req_meta_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            inflight_q[i] <= inflight_q[i-1];
            meta_q[i]     <= meta_q[i-1];
         end
      end
   end

   assign push_entry_s.colour.red   = iRed;
   assign push_entry_s.colour.green = iGreen;
   assign push_entry_s.colour.blue  = iBlue;
   assign push_entry_s.colour.gray  = iGray;
   assign push_entry_s.meta         = meta_q[READ_LATENCY-1];

   pixel_sync_fifo #(
      .DEPTH (BUFFER_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (inflight_q[READ_LATENCY-1]),
      .data_i  (push_entry_s),
      .pop_i   (pop_s),
      .data_o  (head_bits_s),
      .count_o (occupancy_s),
      .empty_o (empty_s)
   );

   assign head_s        = head_bits_s;
   assign oRead         = read_s;
   assign oValid        = !empty_s;
   assign oRed          = head_s.colour.red;
   assign oGreen        = head_s.colour.green;
   assign oBlue         = head_s.colour.blue;
   assign oGray         = head_s.colour.gray;
   assign oX            = head_s.meta.x;
   assign oY            = head_s.meta.y;
   assign oStartOfFrame = oValid && head_s.meta.flags.sof;
   assign oEndOfFrame   = oValid && head_s.meta.flags.eof;
   assign oDone         = done_s;
   assign oBusy         = (state_q != ST_IDLE) && !done_s;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader: a second instance with a two-entry buffer
// runs alongside the first in the unstalled frame.
module tb_sdram_frame_reader;

   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic [DW-1:0] width, height;
   logic          iStart, iReady;
   logic [7:0]    iRed, iGreen, iBlue, iGray;

   logic          oRead, oValid, oSOF, oEOF, oBusy, oDone;
   logic [7:0]    oRed, oGreen, oBlue, oGray;
   logic [DW-1:0] oX, oY;

   logic          oRead2, oValid2, oSOF2, oEOF2, oBusy2, oDone2;
   logic [7:0]    oRed2, oGreen2, oBlue2, oGray2;
   logic [DW-1:0] oX2, oY2;

   int n_assert = 0, n_fail = 0;
   int cyc, fw, fh, drive_idx, n_reads, acc_idx, dones, done_cyc;
   int first_rd, last_rd, first_v, last_v, max_out;
   int acc2_idx, v2_cnt, first_v2, last_v2, rd2;
   logic busy_seen, valid_seen, busy1, busy_at_done;
   logic tog, chk2;

   always #5 clock = ~clock;

   sdram_frame_reader #(.BUFFER_DEPTH(4), .DIM_WIDTH(DW)) u_dut (
      .clock(clock), .reset(reset), .width(width), .height(height), .iStart(iStart),
      .oRead(oRead), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iGray(iGray),
      .oValid(oValid), .iReady(iReady), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
      .oGray(oGray), .oX(oX), .oY(oY), .oStartOfFrame(oSOF), .oEndOfFrame(oEOF),
      .oBusy(oBusy), .oDone(oDone));

   sdram_frame_reader #(.BUFFER_DEPTH(2), .DIM_WIDTH(DW)) u_dut2 (
      .clock(clock), .reset(reset), .width(width), .height(height), .iStart(iStart),
      .oRead(oRead2), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iGray(iGray),
      .oValid(oValid2), .iReady(iReady), .oRed(oRed2), .oGreen(oGreen2), .oBlue(oBlue2),
      .oGray(oGray2), .oX(oX2), .oY(oY2), .oStartOfFrame(oSOF2), .oEndOfFrame(oEOF2),
      .oBusy(oBusy2), .oDone(oDone2));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Colour pattern the controller model returns for the k-th read of a frame.
   function automatic logic [31:0] colours(input int k);
      logic [7:0] b;
      b = k[7:0];
      return {b, ~b, b ^ 8'h5A, b + 8'd100};
   endfunction

   function automatic logic [65:0] exp_pix(input int k);
      logic [15:0] x, y;
      if (fw == 0) return 66'd0;
      x = 16'(k % fw);
      y = 16'(k / fw);
      return {colours(k), x, y, (k == 0), (k == fw * fh - 1)};
   endfunction

   task automatic frame_begin(input int w, input int h);
      fw = w; fh = h; cyc = 0; drive_idx = 0; n_reads = 0; acc_idx = 0; dones = 0;
      done_cyc = -1; first_rd = -1; last_rd = -1; first_v = -1; last_v = -1; max_out = 0;
      acc2_idx = 0; v2_cnt = 0; first_v2 = -1; last_v2 = -1; rd2 = 0;
      busy_seen = 1'b0; valid_seen = 1'b0; busy1 = 1'b0; busy_at_done = 1'b1;
   endtask

   // One clock: observe at the falling edge, then answer reads after the rising edge.
   task automatic step();
      logic rd;
      @(negedge clock);
      rd = oRead;
      if (oBusy) busy_seen = 1'b1;
      if (cyc == 1) busy1 = oBusy;
      if (rd) begin
         n_reads++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
      end
      if (oValid) begin
         valid_seen = 1'b1;
         chk("pixel", 128'({oRed, oGreen, oBlue, oGray, oX, oY, oSOF, oEOF}), 128'(exp_pix(acc_idx)));
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
         if (iReady) acc_idx++;
      end
      if (oDone) begin
         dones++;
         done_cyc = cyc;
         busy_at_done = oBusy;
      end
      if (n_reads - acc_idx > max_out) max_out = n_reads - acc_idx;
      if (chk2) begin
         if (oRead2) rd2++;
         if (oValid2) begin
            chk("pixel_d2", 128'({oRed2, oGreen2, oBlue2, oGray2, oX2, oY2, oSOF2, oEOF2}),
                128'(exp_pix(acc2_idx)));
            acc2_idx++;
            v2_cnt++;
            if (first_v2 < 0) first_v2 = cyc;
            last_v2 = cyc;
         end
      end
      @(posedge clock);
      #1;
      if (rd) begin
         {iRed, iGreen, iBlue, iGray} = colours(drive_idx);
         drive_idx++;
      end else begin
         {iRed, iGreen, iBlue, iGray} = 32'hEEEE_EEEE;
      end
      cyc++;
      if (tog) iReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
   endtask

   task automatic start_frame(input int w, input int h);
      frame_begin(w, h);
      width = DW'(w); height = DW'(h); iStart = 1'b1;
      step();
      iStart = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      for (int i = 0; i < budget && dones == 0; i++) step();
      chk("done_seen", 128'(dones), 128'(1));
   endtask

   initial begin
      reset = 1'b1; iStart = 1'b0; iReady = 1'b1; width = '0; height = '0;
      {iRed, iGreen, iBlue, iGray} = 32'h0;
      tog = 1'b0; chk2 = 1'b0;
      frame_begin(0, 0);
      repeat (2) @(posedge clock);
      #1;
      chk("reset_ctl", 128'({oRead, oValid, oBusy, oDone, oSOF, oEOF}), 128'(6'b0));
      chk("reset_data", 128'({oRed, oGreen, oBlue, oGray, oX, oY}), 128'(0));
      reset = 1'b0;
      step();

      // 4x2 frame, always ready; the depth-2 instance must also stream without bubbles.
      chk2 = 1'b1;
      start_frame(4, 2);
      run_to_done(40);
      step();
      chk("f1_reads", 128'(n_reads), 128'(8));
      chk("f1_first_rd", 128'(first_rd), 128'(1));
      chk("f1_last_rd", 128'(last_rd), 128'(8));
      chk("f1_first_v", 128'(first_v), 128'(3));
      chk("f1_last_v", 128'(last_v), 128'(10));
      chk("f1_done_cyc", 128'(done_cyc), 128'(10));
      chk("f1_accepted", 128'(acc_idx), 128'(8));
      chk("f1_busy1", 128'(busy1), 128'(1));
      chk("f1_busy_at_done", 128'(busy_at_done), 128'(0));
      chk("f1_busy_after", 128'(oBusy), 128'(0));
      chk("d2_reads", 128'(rd2), 128'(8));
      chk("d2_valid_cnt", 128'(v2_cnt), 128'(8));
      chk("d2_first_v", 128'(first_v2), 128'(3));
      chk("d2_last_v", 128'(last_v2), 128'(10));
      chk2 = 1'b0;

      // Same frame with iReady toggling 1,0,0,1.
      tog = 1'b1;
      start_frame(4, 2);
      run_to_done(80);
      tog = 1'b0; iReady = 1'b1;
      step();
      chk("f2_reads", 128'(n_reads), 128'(8));
      chk("f2_accepted", 128'(acc_idx), 128'(8));
      chk("f2_dones", 128'(dones), 128'(1));
      chk("f2_occupancy", 128'(max_out <= 4), 128'(1));

      // Zero width, then zero height: nothing happens.
      start_frame(0, 2);
      repeat (6) step();
      chk("w0_reads", 128'(n_reads), 128'(0));
      chk("w0_busy", 128'(busy_seen), 128'(0));
      chk("w0_done", 128'(dones), 128'(0));
      start_frame(3, 0);
      repeat (6) step();
      chk("h0_reads", 128'(n_reads), 128'(0));
      chk("h0_busy", 128'(busy_seen), 128'(0));
      chk("h0_done", 128'(dones), 128'(0));

      // iStart with a different width while the 3x2 frame is running is ignored.
      start_frame(3, 2);
      step();
      step();
      width = DW'(5); iStart = 1'b1;
      step();
      iStart = 1'b0;
      run_to_done(40);
      repeat (3) step();
      chk("rs_reads", 128'(n_reads), 128'(6));
      chk("rs_accepted", 128'(acc_idx), 128'(6));
      chk("rs_dones", 128'(dones), 128'(1));

      // Reset after the third accepted pixel, then restart from (0,0).
      start_frame(4, 2);
      for (int i = 0; i < 20 && acc_idx < 3; i++) step();
      chk("mid_progress", 128'(acc_idx), 128'(3));
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_ctl", 128'({oRead, oValid, oBusy, oDone, oSOF, oEOF}), 128'(6'b0));
      chk("mid_rst_data", 128'({oRed, oGreen, oBlue, oGray, oX, oY}), 128'(0));
      frame_begin(4, 2);
      repeat (3) step();
      chk("mid_empty", 128'({valid_seen, busy_seen, dones != 0}), 128'(3'b000));
      start_frame(4, 2);
      run_to_done(40);
      chk("restart_reads", 128'(n_reads), 128'(8));
      chk("restart_accepted", 128'(acc_idx), 128'(8));
      chk("restart_first_v", 128'(first_v), 128'(3));

      // 1x1 frame: single pixel carries both markers.
      step();
      start_frame(1, 1);
      run_to_done(20);
      chk("one_reads", 128'(n_reads), 128'(1));
      chk("one_accepted", 128'(acc_idx), 128'(1));
      chk("one_done_cyc", 128'(done_cyc), 128'(3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
